// File: rtl/ps2_history_display.sv
// PS/2 scancode history viewer: decodes E0/F0 prefixes, keeps the last NUM_DIGITS/2
// committed bytes and scans them as hex onto a common-anode 7-segment display.
module ps2_history_display #(
  parameter int NUM_DIGITS      = 4,
  parameter int REFRESH_CYCLES  = 100000,
  parameter int LED_HOLD_CYCLES = 25000000,
  parameter int SHOW_BREAK      = 0
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  key_valid,
  input  logic [7:0]            scancode,
  input  logic                  clear,
  output logic [6:0]            seg,
  output logic [NUM_DIGITS-1:0] an,
  output logic                  dp,
  output logic                  led
);

  localparam int DEPTH = NUM_DIGITS / 2;
  localparam int IDXW  = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int REFW  = (REFRESH_CYCLES > 1) ? $clog2(REFRESH_CYCLES) : 1;
  localparam int LEDW  = (LED_HOLD_CYCLES > 0) ? $clog2(LED_HOLD_CYCLES + 1) : 1;
  localparam bit KEEP_BREAK = (SHOW_BREAK != 0);

  typedef struct packed {
    logic       valid;
    logic       ext;
    logic       brk;
    logic [7:0] data;
  } slot_t;

  typedef enum logic [1:0] {IDLE, EXT, BRK, EXT_BRK} state_t;

  state_t            state, state_next;
  logic              commit, commit_ext, commit_brk, store;
  slot_t             slots [DEPTH];
  logic [REFW-1:0]   refresh_cnt;
  logic [IDXW-1:0]   idx;
  logic [LEDW-1:0]   led_cnt;
  slot_t             cur;
  logic              high;
  logic [3:0]        nibble;
  logic [6:0]        seg_next;
  logic              dp_next;

  function automatic logic [6:0] hex_font(input logic [3:0] n);
    case (n)
      4'h0: hex_font = 7'h40;
      4'h1: hex_font = 7'h79;
      4'h2: hex_font = 7'h24;
      4'h3: hex_font = 7'h30;
      4'h4: hex_font = 7'h19;
      4'h5: hex_font = 7'h12;
      4'h6: hex_font = 7'h02;
      4'h7: hex_font = 7'h78;
      4'h8: hex_font = 7'h00;
      4'h9: hex_font = 7'h10;
      4'hA: hex_font = 7'h08;
      4'hB: hex_font = 7'h03;
      4'hC: hex_font = 7'h46;
      4'hD: hex_font = 7'h21;
      4'hE: hex_font = 7'h06;
      default: hex_font = 7'h0E;
    endcase
  endfunction

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state <= IDLE;
    else       state <= state_next;
  end

  // Prefix bytes accumulate into EXT/BRK flags; any other byte commits and returns to IDLE.
  always_comb begin
    state_next = state;
    commit     = 1'b0;
    commit_ext = 1'b0;
    commit_brk = 1'b0;
    if (clear) begin
      state_next = IDLE;
    end else if (key_valid) begin
      case (state)
        IDLE: begin
          if (scancode == 8'hE0)      state_next = EXT;
          else if (scancode == 8'hF0) state_next = BRK;
          else begin
            commit = 1'b1; state_next = IDLE;
          end
        end
        EXT: begin
          if (scancode == 8'hE0)      state_next = EXT;
          else if (scancode == 8'hF0) state_next = EXT_BRK;
          else begin
            commit = 1'b1; commit_ext = 1'b1; state_next = IDLE;
          end
        end
        BRK: begin
          if (scancode == 8'hE0)      state_next = EXT_BRK;
          else if (scancode == 8'hF0) state_next = BRK;
          else begin
            commit = 1'b1; commit_brk = 1'b1; state_next = IDLE;
          end
        end
        default: begin
          if (scancode == 8'hE0 || scancode == 8'hF0) state_next = EXT_BRK;
          else begin
            commit = 1'b1; commit_ext = 1'b1; commit_brk = 1'b1; state_next = IDLE;
          end
        end
      endcase
    end
  end

  assign store = commit & (~commit_brk | KEEP_BREAK);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int j = 0; j < DEPTH; j++) slots[j] <= '0;
    end else if (clear) begin
      for (int j = 0; j < DEPTH; j++) slots[j] <= '0;
    end else if (store) begin
      for (int k = DEPTH - 1; k > 0; k--) slots[k] <= slots[k-1];
      slots[0] <= {1'b1, commit_ext, commit_brk, scancode};
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      refresh_cnt <= '0;
      idx         <= '0;
    end else if (refresh_cnt == REFW'(REFRESH_CYCLES - 1)) begin
      refresh_cnt <= '0;
      idx         <= (idx == IDXW'(NUM_DIGITS - 1)) ? '0 : idx + 1'b1;
    end else begin
      refresh_cnt <= refresh_cnt + 1'b1;
    end
  end

  // Even digits show the low nibble and break flag, odd digits the high nibble and ext flag.
  always_comb begin
    cur  = '0;
    high = 1'b0;
    for (int d = 0; d < NUM_DIGITS; d++) begin
      if (idx == IDXW'(d)) begin
        cur  = slots[d/2];
        high = ((d % 2) == 1);
      end
    end
    nibble   = high ? cur.data[7:4] : cur.data[3:0];
    seg_next = cur.valid ? hex_font(nibble) : 7'h7F;
    dp_next  = cur.valid ? ~(high ? cur.ext : cur.brk) : 1'b1;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      seg <= 7'h7F;
      an  <= '1;
      dp  <= 1'b1;
    end else begin
      seg <= seg_next;
      an  <= ~(NUM_DIGITS'(1) << idx);
      dp  <= dp_next;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      led_cnt <= '0;
      led     <= 1'b0;
    end else begin
      if (clear)               led_cnt <= '0;
      else if (store)          led_cnt <= LEDW'(LED_HOLD_CYCLES);
      else if (led_cnt != '0)  led_cnt <= led_cnt - 1'b1;
      led <= (led_cnt != '0);
    end
  end

endmodule
